opfetch_seq: RTL and testbench

- Operand-fetch sequencer between decode and execute.
- Accepts one decoded instruction (rs1/rs2 addresses plus payload) and reads both source operands through the register file's single combinational read port, one per cycle.
- Holds the operands stable for execute until consumed, and snoops the writeback port so held operands never go stale.
- Drives the register file's raddr_i and consumes its rdata_o.

---
 rtl/opfetch_seq.sv | 154 +++++++++++++++
 tb/tb_opfetch_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opfetch_seq.sv
// Operand-fetch sequencer: reads rs1/rs2 through one register file read port, then holds
// snooped operands for execute. Optional define OPFETCH_SAME_REG_MERGE_EN skips RD2 when rs1==rs2.
module opfetch_seq #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RAW  = 5,
  parameter int unsigned PW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [RAW-1:0]  in_rs1_i,
  input  logic [RAW-1:0]  in_rs2_i,
  input  logic            in_rs1_en_i,
  input  logic            in_rs2_en_i,
  input  logic [PW-1:0]   in_payload_i,
  output logic [RAW-1:0]  rf_raddr_o,
  input  logic [XLEN-1:0] rf_rdata_i,
  input  logic            wb_we_i,
  input  logic [RAW-1:0]  wb_waddr_i,
  input  logic [XLEN-1:0] wb_wdata_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_op1_o,
  output logic [XLEN-1:0] out_op2_o,
  output logic [PW-1:0]   out_payload_o
);

  typedef enum logic [1:0] {StIdle, StRd1, StRd2, StHold} state_e;

  state_e          state_q, state_d;
  logic [RAW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic            rs1_en_q, rs1_en_d, rs2_en_q, rs2_en_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [PW-1:0]   payload_q, payload_d;

  logic            accept;
  logic            merge;
  logic            wb_hit;
  logic            snoop1, snoop2;
  logic [XLEN-1:0] rd1_val, rd2_val;

  assign accept = in_valid_i & (state_q == StIdle) & ~flush_i;

`ifdef OPFETCH_SAME_REG_MERGE_EN
  assign merge = rs1_en_q & rs2_en_q & (rs1_q == rs2_q);
`else
  assign merge = 1'b0;
`endif

  // An operand only snoops once its own read has retired; disabled operands never change.
  assign wb_hit = wb_we_i & (wb_waddr_i != '0);
  assign snoop1 = wb_hit & (wb_waddr_i == rs1_q) & rs1_en_q &
                  ((state_q == StRd2) | (state_q == StHold));
  assign snoop2 = wb_hit & (wb_waddr_i == rs2_q) & rs2_en_q & (state_q == StHold);

  assign rd1_val = (rs1_q == '0) ? '0 : rf_rdata_i;
  assign rd2_val = (rs2_q == '0) ? '0 : rf_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_rs1_en_i)      state_d = StRd1;
            else if (in_rs2_en_i) state_d = StRd2;
            else                  state_d = StHold;
          end
        end
        StRd1:   state_d = (rs2_en_q & ~merge) ? StRd2 : StHold;
        StRd2:   state_d = StHold;
        StHold:  if (out_ready_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle) & ~flush_i;
    out_valid_o = (state_q == StHold);
    rf_raddr_o  = '0;
    unique case (state_q)
      StRd1:   rf_raddr_o = rs1_q;
      StRd2:   rf_raddr_o = rs2_q;
      default: rf_raddr_o = '0;
    endcase
  end

  // Flush freezes every datapath register, including pending snoops.
  always_comb begin
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rs1_en_d  = rs1_en_q;
    rs2_en_d  = rs2_en_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    payload_d = payload_q;
    if (!flush_i) begin
      if (accept) begin
        rs1_d     = in_rs1_i;
        rs2_d     = in_rs2_i;
        rs1_en_d  = in_rs1_en_i;
        rs2_en_d  = in_rs2_en_i;
        payload_d = in_payload_i;
        op1_d     = '0;
        op2_d     = '0;
      end
      if (snoop1) op1_d = wb_wdata_i;
      if (snoop2) op2_d = wb_wdata_i;
      if (state_q == StRd1) begin
        op1_d = rd1_val;
        if (merge) op2_d = rd1_val;
      end
      if (state_q == StRd2) op2_d = rd2_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_en_q  <= 1'b0;
      rs2_en_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      payload_q <= '0;
    end else begin
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rs1_en_q  <= rs1_en_d;
      rs2_en_q  <= rs2_en_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      payload_q <= payload_d;
    end
  end

  assign out_op1_o     = op1_q;
  assign out_op2_o     = op2_q;
  assign out_payload_o = payload_q;

endmodule

// File: tb/tb_opfetch_seq.sv
// Bench for opfetch_seq: directed steps then random traffic against an architectural
// register model (held operands must always equal the current register contents).
module tb_opfetch_seq;

`ifdef OPFETCH_SAME_REG_MERGE_EN
  localparam bit MergeEn = 1'b1;
`else
  localparam bit MergeEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rs1_en, in_rs2_en;
  logic [4:0]  in_rs1, in_rs2;
  logic [63:0] in_payload;
  logic [4:0]  rf_raddr;
  logic [63:0] rf_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        flush, out_valid, out_ready;
  logic [63:0] out_op1, out_op2, out_payload;

  logic [63:0] regs [32];
  logic [4:0]  cur_rs1, cur_rs2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (wb_we) regs[wb_waddr] <= wb_wdata;

  // Register file read port with same-cycle write forwarding.
  assign rf_rdata = (wb_we && wb_waddr == rf_raddr) ? wb_wdata : regs[rf_raddr];

  opfetch_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_rs1_i     (in_rs1),
    .in_rs2_i     (in_rs2),
    .in_rs1_en_i  (in_rs1_en),
    .in_rs2_en_i  (in_rs2_en),
    .in_payload_i (in_payload),
    .rf_raddr_o   (rf_raddr),
    .rf_rdata_i   (rf_rdata),
    .wb_we_i      (wb_we),
    .wb_waddr_i   (wb_waddr),
    .wb_wdata_i   (wb_wdata),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_op1_o    (out_op1),
    .out_op2_o    (out_op2),
    .out_payload_o(out_payload)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [63:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    nxt();
    wb_we = 1'b0;
  endtask

  task automatic drive_wb();
    wb_we    = ($urandom_range(0, 2) != 0);
    wb_wdata = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       wb_waddr = cur_rs1;
      1:       wb_waddr = cur_rs2;
      2:       wb_waddr = 5'd0;
      default: wb_waddr = 5'($urandom_range(0, 31));
    endcase
  endtask

  // Called just after a posedge; returns one cycle later with the instruction accepted.
  task automatic accept(input logic [4:0] r1, input logic [4:0] r2, input logic e1,
                        input logic e2, input logic [63:0] p);
    in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rs1_en = e1; in_rs2_en = e2;
    in_payload = p; cur_rs1 = r1; cur_rs2 = r2;
    @(negedge clk);
    check("accept_ready", 64'(in_ready), 64'd1);
    nxt();
    in_valid = 1'b0;
  endtask

  // Cycles from accept to first out_valid; ends on a negedge when found, -1 if never.
  task automatic wait_valid(input bit rnd, output int lat);
    bit found = 1'b0;
    lat = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      nxt();
      if (rnd) drive_wb();
      lat++;
    end
    if (!found) lat = -1;
  endtask

  function automatic logic [63:0] model_op(input logic en, input logic [4:0] rs);
    return (en && rs != 5'd0) ? regs[rs] : 64'd0;
  endfunction

  initial begin
    int          lat, want_lat, k;
    bit          done;
    logic [4:0]  r1, r2;
    logic        e1, e2;
    logic [63:0] p;

    rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rs1_en = 1'b0;
    in_rs2_en = 1'b0; in_payload = '0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    flush = 1'b0; out_ready = 1'b0; cur_rs1 = '0; cur_rs2 = '0;

    for (int i = 0; i < 32; i++) wb_write(5'(i), {$urandom, $urandom} | 64'h1);
    wb_write(5'd5, 64'h11);
    wb_write(5'd6, 64'h22);
    wb_write(5'd7, 64'h1234);
    wb_write(5'd9, 64'h3);

    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_op1", out_op1, 64'd0);
    check("rst_op2", out_op2, 64'd0);
    check("rst_payload", out_payload, 64'd0);
    check("rst_raddr", 64'(rf_raddr), 64'd0);
    nxt();
    rst = 1'b0;

    // Both sources, back-to-back reads, handshake
    accept(5'd5, 5'd6, 1'b1, 1'b1, 64'h1111);
    @(negedge clk);
    check("rd1_raddr", 64'(rf_raddr), 64'd5);
    check("rd1_valid", 64'(out_valid), 64'd0);
    nxt();
    @(negedge clk);
    check("rd2_raddr", 64'(rf_raddr), 64'd6);
    nxt();
    @(negedge clk);
    check("both_valid", 64'(out_valid), 64'd1);
    check("both_op1", out_op1, 64'h11);
    check("both_op2", out_op2, 64'h22);
    check("both_payload", out_payload, 64'h1111);
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    @(negedge clk);
    check("hs_valid", 64'(out_valid), 64'd0);
    check("hs_ready", 64'(in_ready), 64'd1);
    nxt();

    // rs1=x0 enabled, rs2 disabled
    accept(5'd0, 5'd4, 1'b1, 1'b0, 64'hABCD);
    @(negedge clk);
    check("x0_rd_valid", 64'(out_valid), 64'd0);
    nxt();
    @(negedge clk);
    check("x0_valid", 64'(out_valid), 64'd1);
    check("x0_op1", out_op1, 64'd0);
    check("x0_op2", out_op2, 64'd0);
    check("x0_payload", out_payload, 64'hABCD);
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;

    // Snoop in HOLD; disabled rs1 aliases x7 and must stay 0
    accept(5'd7, 5'd7, 1'b0, 1'b1, 64'h77);
    @(negedge clk);
    check("snp_raddr", 64'(rf_raddr), 64'd7);
    nxt();
    @(negedge clk);
    check("snp_valid", 64'(out_valid), 64'd1);
    check("snp_op2_init", out_op2, 64'h1234);
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 64'h99;
    nxt();
    wb_we = 1'b0;
    @(negedge clk);
    check("snp_op2_upd", out_op2, 64'h99);
    check("snp_op1_dis", out_op1, 64'd0);
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 64'h5;
    nxt();
    wb_we = 1'b0;
    @(negedge clk);
    check("snp_x0_op2", out_op2, 64'h99);
    check("snp_x0_op1", out_op1, 64'd0);
    flush = 1'b1; wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 64'h55;
    nxt();
    flush = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("hflush_valid", 64'(out_valid), 64'd0);
    check("hflush_op2", out_op2, 64'h99);
    check("hflush_ready", 64'(in_ready), 64'd1);
    nxt();

    // Flush during RD1, then flush blocking accept in IDLE
    accept(5'd3, 5'd0, 1'b1, 1'b0, 64'h33);
    flush = 1'b1;
    @(negedge clk);
    check("fl_rd1_raddr", 64'(rf_raddr), 64'd3);
    check("fl_rd1_ready", 64'(in_ready), 64'd0);
    nxt();
    flush = 1'b0;
    @(negedge clk);
    check("fl_valid0", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    nxt();
    @(negedge clk);
    check("fl_valid1", 64'(out_valid), 64'd0);
    nxt();
    in_valid = 1'b1; in_rs1_en = 1'b0; in_rs2_en = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl_idle_ready", 64'(in_ready), 64'd0);
    nxt();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fl_idle_noacc", 64'(out_valid), 64'd0);
    check("fl_idle_ready2", 64'(in_ready), 64'd1);
    nxt();

    // Same register on both sources
    accept(5'd9, 5'd9, 1'b1, 1'b1, 64'h99);
    wait_valid(1'b0, lat);
    check("same_lat", 64'(lat), MergeEn ? 64'd2 : 64'd3);
    check("same_op1", out_op1, 64'h3);
    check("same_op2", out_op2, 64'h3);
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    nxt();

    // Asynchronous reset in the middle of RD2
    accept(5'd5, 5'd6, 1'b1, 1'b1, 64'h5656);
    nxt();
    check("arst_pre_raddr", 64'(rf_raddr), 64'd6);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_op1", out_op1, 64'd0);
    check("arst_op2", out_op2, 64'd0);
    check("arst_payload", out_payload, 64'd0);
    check("arst_raddr", 64'(rf_raddr), 64'd0);
    nxt();
    rst = 1'b0;

    // Random traffic with random writebacks every cycle
    for (int t = 0; t < 150; t++) begin
      r1 = 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 7));
      e1 = 1'($urandom_range(0, 1));
      e2 = 1'($urandom_range(0, 1));
      p  = {$urandom, $urandom};
      cur_rs1 = r1; cur_rs2 = r2;
      drive_wb();
      accept(r1, r2, e1, e2, p);
      drive_wb();
      want_lat = 1 + int'(e1) + int'(e2);
      if (MergeEn && e1 && e2 && r1 == r2) want_lat--;
      wait_valid(1'b1, lat);
      check("rnd_lat", 64'(lat), 64'(want_lat));
      if (lat < 0) begin
        out_ready = 1'b1;
        repeat (10) nxt();
        out_ready = 1'b0;
      end else begin
        done = 1'b0;
        k = 0;
        while (!done) begin
          check("rnd_op1", out_op1, model_op(e1, r1));
          check("rnd_op2", out_op2, model_op(e2, r2));
          check("rnd_payload", out_payload, p);
          out_ready = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          nxt();
          done = out_ready;
          out_ready = 1'b0;
          drive_wb();
          k++;
          @(negedge clk);
          if (done) check("rnd_release", 64'(out_valid), 64'd0);
          else      check("rnd_hold", 64'(out_valid), 64'd1);
        end
      end
      nxt();
    end

    wb_we = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
